instruction_fetch_stage: RTL and testbench

- Initiator side of the instruction memory interface, i.e. the IF pipeline stage.
- Holds the PC and drives the byte address to the combinational instruction memory.
- Captures the returned 32-bit word into the IF/ID pipeline register.
- Handles hazard freeze and branch redirect/flush, and keeps a saturating fetch counter for bring-up.

---
 rtl/instruction_fetch_stage.sv | 81 ++++++++
 tb/tb_instruction_fetch_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch (IF) pipeline stage.
// Holds the program counter, addresses a zero-latency instruction memory and
// captures the returned word into the IF/ID pipeline register. Branches
// redirect the PC and flush IF/ID with a NOP bubble. Hazard freezes hold the
// whole stage. A saturating counter tracks accepted fetches for bring-up.
module instruction_fetch_stage #(
  parameter int                  INST_LEN = 32,
  parameter int                  MEM_SIZE = 1024,
  parameter logic [INST_LEN-1:0] RESET_PC = '0,
  parameter logic [INST_LEN-1:0] NOP      = 'hE000_0000,
  parameter int                  CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [INST_LEN-1:0] branch_addr,
  output logic [INST_LEN-1:0] imem_address,
  input  logic [INST_LEN-1:0] imem_data,
  output logic [INST_LEN-1:0] pc_out,
  output logic [INST_LEN-1:0] instruction_out,
  output logic                valid_out,
  output logic [CNT_W-1:0]    fetch_count
);

  // MEM_SIZE is a power of two, so masking with MEM_SIZE-1 wraps addresses
  // inside the memory. Clearing the low two bits as well word-aligns targets.
  localparam logic [INST_LEN-1:0] ADDR_MASK   = INST_LEN'(MEM_SIZE - 1);
  localparam logic [INST_LEN-1:0] TARGET_MASK = ADDR_MASK & ~INST_LEN'(3);

  logic [INST_LEN-1:0] pc;
  logic [INST_LEN-1:0] pc_plus4;
  logic [INST_LEN-1:0] branch_target;
  logic                count_full;

  assign pc_plus4      = (pc + INST_LEN'(4)) & ADDR_MASK;
  assign branch_target = branch_addr & TARGET_MASK;
  assign count_full    = &fetch_count;

  // The memory is combinational, so the PC register drives it directly.
  assign imem_address = pc;

  // PC register: a branch beats a freeze; otherwise advance sequentially.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= branch_target;
    end else if (!freeze) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID register: a branch flushes to a bubble, a freeze holds, otherwise
  // the word addressed this cycle is captured together with its PC+4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction_out <= NOP;
      pc_out          <= '0;
      valid_out       <= 1'b0;
    end else if (branch_taken) begin
      instruction_out <= NOP;
      pc_out          <= '0;
      valid_out       <= 1'b0;
    end else if (!freeze) begin
      instruction_out <= imem_data;
      pc_out          <= pc_plus4;
      valid_out       <= 1'b1;
    end
  end

  // Fetch counter: counts only real captures into IF/ID and sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (!branch_taken && !freeze && !count_full) begin
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage.
// Two instances share clock and control: a default one, and one that starts
// near the top of memory with a 4-bit counter so that wrap and counter
// saturation are both exercised. A reference model predicts each edge and
// pushes the prediction into a queue; a monitor pops and compares.
module tb_instruction_fetch_stage;

  localparam int          MEM  = 1024;
  localparam logic [31:0] NOPW = 32'hE000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcOut;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;

  logic [31:0] addr0, data0, pcOut0, instr0;
  logic        valid0;
  logic [15:0] cnt0;
  logic [31:0] addr1, data1, pcOut1, instr1;
  logic        valid1;
  logic [3:0]  cnt1;

  logic [31:0] mem [MEM/4];

  exp_t q0[$];
  exp_t q1[$];

  int          mPc [2];
  int          mPcOut [2];
  int          mCnt [2];
  logic [31:0] mInstr [2];
  logic        mValid [2];

  int vectors = 0;
  int miscompares = 0;

  assign data0 = mem[addr0[9:2]];
  assign data1 = mem[addr1[9:2]];

  always #5 clk = ~clk;

  instruction_fetch_stage dut0 (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_address(addr0), .imem_data(data0),
    .pc_out(pcOut0), .instruction_out(instr0), .valid_out(valid0),
    .fetch_count(cnt0)
  );

  instruction_fetch_stage #(.RESET_PC(32'd1016), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_address(addr1), .imem_data(data1),
    .pc_out(pcOut1), .instruction_out(instr1), .valid_out(valid1),
    .fetch_count(cnt1)
  );

  function automatic int resetPcOf(int k);
    return (k == 0) ? 0 : 1016;
  endfunction

  function automatic int cntMaxOf(int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mPc[k]    = resetPcOf(k);
      mPcOut[k] = 0;
      mCnt[k]   = 0;
      mInstr[k] = NOPW;
      mValid[k] = 1'b0;
    end
  endtask

  // Behavioural view: a branch jumps to the word-aligned target inside memory
  // and leaves a bubble; a freeze changes nothing; otherwise the word at PC is
  // taken, PC moves to the next word (wrapping) and one more fetch is counted.
  task automatic modelStep(input int k, input logic frz, input logic br, input logic [31:0] baddr);
    if (br) begin
      mPc[k]    = int'((baddr % MEM) / 4) * 4;
      mInstr[k] = NOPW;
      mPcOut[k] = 0;
      mValid[k] = 1'b0;
    end else if (!frz) begin
      mInstr[k] = mem[mPc[k] / 4];
      mPc[k]    = (mPc[k] + 4) % MEM;
      mPcOut[k] = mPc[k];
      mValid[k] = 1'b1;
      if (mCnt[k] < cntMaxOf(k)) mCnt[k]++;
    end
  endtask

  task automatic applyStimulus(input logic frz, input logic br, input logic [31:0] baddr);
    exp_t e;
    @(negedge clk);
    freeze       = frz;
    branch_taken = br;
    branch_addr  = baddr;
    for (int k = 0; k < 2; k++) begin
      modelStep(k, frz, br, baddr);
      e.addr  = mPc[k];
      e.instr = mInstr[k];
      e.pcOut = mPcOut[k];
      e.valid = mValid[k];
      e.cnt   = mCnt[k];
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // Drops reset a few ns after a rising edge and checks that outputs change
  // before the next edge; releases reset clear of any clock edge.
  task automatic resetMidCycle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_addr0", addr0, 32'd0);
    checkOutput("rst_instr0", instr0, NOPW);
    checkOutput("rst_pcout0", pcOut0, 32'd0);
    checkOutput("rst_valid0", {31'd0, valid0}, 32'd0);
    checkOutput("rst_cnt0", {16'd0, cnt0}, 32'd0);
    checkOutput("rst_addr1", addr1, 32'd1016);
    checkOutput("rst_instr1", instr1, NOPW);
    checkOutput("rst_pcout1", pcOut1, 32'd0);
    checkOutput("rst_valid1", {31'd0, valid1}, 32'd0);
    checkOutput("rst_cnt1", {28'd0, cnt1}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: after every rising edge compare each instance with its queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checkOutput("addr0", addr0, e.addr);
        checkOutput("instr0", instr0, e.instr);
        checkOutput("pcout0", pcOut0, e.pcOut);
        checkOutput("valid0", {31'd0, valid0}, {31'd0, e.valid});
        checkOutput("cnt0", {16'd0, cnt0}, e.cnt);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checkOutput("addr1", addr1, e.addr);
        checkOutput("instr1", instr1, e.instr);
        checkOutput("pcout1", pcOut1, e.pcOut);
        checkOutput("valid1", {31'd0, valid1}, {31'd0, e.valid});
        checkOutput("cnt1", {28'd0, cnt1}, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    logic [31:0] ba;
    for (int i = 0; i < MEM / 4; i++) mem[i] = 32'(i + 1);
    modelReset();
    resetMidCycle();

    // Sequential fetch, then a 3-cycle freeze at pc=8, then release.
    applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);

    // Branch with freeze also high: branch wins, then the target arrives.
    applyStimulus(1'b1, 1'b1, 32'h0000_0103);
    applyStimulus(1'b0, 1'b0, 32'd0);

    // Long unfrozen run: the 4-bit counter must saturate and stay at 15.
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 32'd0);

    // Reach pc=0x40 with five fetches counted, then reset mid-cycle.
    resetMidCycle();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0000_003C);
    applyStimulus(1'b0, 1'b0, 32'd0);
    resetMidCycle();

    // Random phase with fresh memory contents.
    for (int i = 0; i < MEM / 4; i++) mem[i] = $urandom;
    for (int i = 0; i < 120; i++) begin
      r  = int'($urandom_range(0, 99));
      ba = (r < 4) ? 32'(1020 + $urandom_range(0, 3)) : $urandom;
      applyStimulus(r >= 10 && r < 35, r < 12, ba);
    end

    @(posedge clk);
    #2;
    checkOutput("drain0", 32'(q0.size()), 32'd0);
    checkOutput("drain1", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
